// File: rtl/sram_emu_master_if.sv
// Request/response handshake bundle between the digital requester and sram_emu_master.
// The requester side uses the master modport and the SRAM initiator uses the slave modport.
interface sram_emu_master_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_we;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_we,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_we,
        output rsp_rdata
    );

endinterface

// File: rtl/sram_emu_master.sv
// Digital initiator for the emulated mixed-signal SRAM: sequences the analog-coded
// clk/we/addr/din pins for one request at a time and slices dout_a back into bits.
module sram_emu_master #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int ANA_WIDTH    = 8,
    parameter int FULL_SCALE   = 255,
    parameter int THRESHOLD    = 128,
    parameter int SETUP_CYC    = 1,
    parameter int CLK_HIGH_CYC = 2,
    parameter int RD_WAIT_CYC  = 4
) (
    input  logic                                  clk_d,
    input  logic                                  rst_d,
    sram_emu_master_if.slave                      bus,
    output logic                                  busy,
    output logic [ANA_WIDTH-1:0]                  clk_a,
    output logic [ANA_WIDTH-1:0]                  we_a,
    output logic [ADDR_WIDTH-1:0][ANA_WIDTH-1:0]  addr_a,
    output logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0]  din_a,
    input  logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0]  dout_a
);

    localparam int MAX_AB  = (SETUP_CYC > CLK_HIGH_CYC) ? SETUP_CYC : CLK_HIGH_CYC;
    localparam int MAX_CYC = (MAX_AB > RD_WAIT_CYC) ? MAX_AB : RD_WAIT_CYC;
    localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [ANA_WIDTH-1:0] FS_LVL  = FULL_SCALE[ANA_WIDTH-1:0];
    localparam logic [ANA_WIDTH-1:0] THR_LVL = THRESHOLD[ANA_WIDTH-1:0];

    // Counters hold "cycles remaining after this one", so a phase ends when they reach zero.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] CLKHI_LD = CNT_W'(CLK_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(RD_WAIT_CYC - 1);

    if (SETUP_CYC < 1 || CLK_HIGH_CYC < 1 || RD_WAIT_CYC < 1 || THRESHOLD >= FULL_SCALE) begin : g_param_check
        $error("sram_emu_master: illegal parameter set");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CLK_HI,
        ST_WAIT,
        ST_SAMPLE,
        ST_RESP
    } state_t;

    state_t                               state;
    state_t                               next_state;
    logic [CNT_W-1:0]                     phase_cnt;
    logic                                 we_latched;
    logic                                 accept;
    logic                                 rsp_done;
    logic [ADDR_WIDTH-1:0][ANA_WIDTH-1:0] enc_addr;
    logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0] enc_din;
    logic [DATA_WIDTH-1:0]                sliced;

    assign accept   = (state == ST_IDLE) && bus.req_valid && bus.req_ready;
    assign rsp_done = (state == ST_RESP) && bus.rsp_valid && bus.rsp_ready;

    always_comb begin
        enc_addr = '0;
        enc_din  = '0;
        sliced   = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            enc_addr[i] = bus.req_addr[i] ? FS_LVL : '0;
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            enc_din[i] = bus.req_wdata[i] ? FS_LVL : '0;
            sliced[i]  = (dout_a[i] > THR_LVL);
        end
    end

    always_ff @(posedge clk_d or posedge rst_d) begin
        if (rst_d) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept) next_state = ST_SETUP;
            ST_SETUP:  if (phase_cnt == '0) next_state = ST_CLK_HI;
            ST_CLK_HI: if (phase_cnt == '0) next_state = ST_WAIT;
            ST_WAIT:   if (phase_cnt == '0) next_state = ST_SAMPLE;
            ST_SAMPLE: next_state = ST_RESP;
            ST_RESP:   if (rsp_done) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_d or posedge rst_d) begin
        if (rst_d) begin
            phase_cnt <= '0;
        end else if (next_state != state) begin
            case (next_state)
                ST_SETUP:  phase_cnt <= SETUP_LD;
                ST_CLK_HI: phase_cnt <= CLKHI_LD;
                ST_WAIT:   phase_cnt <= WAIT_LD;
                default:   phase_cnt <= '0;
            endcase
        end else if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - 1'b1;
        end
    end

    // Outputs are derived from next_state so that each registered level lines up with its phase.
    always_ff @(posedge clk_d or posedge rst_d) begin
        if (rst_d) begin
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_we    <= 1'b0;
            bus.rsp_rdata <= '0;
            busy          <= 1'b0;
            clk_a         <= '0;
            we_a          <= '0;
            addr_a        <= '0;
            din_a         <= '0;
            we_latched    <= 1'b0;
        end else begin
            bus.req_ready <= (next_state == ST_IDLE);
            busy          <= (next_state != ST_IDLE);
            clk_a         <= (next_state == ST_CLK_HI) ? FS_LVL : '0;

            if (accept) begin
                we_latched <= bus.req_we;
                we_a       <= bus.req_we ? FS_LVL : '0;
                addr_a     <= enc_addr;
                din_a      <= enc_din;
            end

            if (state == ST_SAMPLE) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_we    <= we_latched;
                bus.rsp_rdata <= we_latched ? '0 : sliced;
            end

            // addr_a/din_a deliberately keep their last levels; only we_a returns to 0.
            if (rsp_done) begin
                bus.rsp_valid <= 1'b0;
                we_a          <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_emu_master.sv
// Directed self-checking bench for sram_emu_master with a behavioural analog-coded SRAM model.
module tb_sram_emu_master;

    logic clk_d;
    logic rst_d;
    logic busy;
    logic [7:0]       clk_a;
    logic [7:0]       we_a;
    logic [3:0][7:0]  addr_a;
    logic [7:0][7:0]  din_a;
    logic [7:0][7:0]  dout_a;

    sram_emu_master_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    sram_emu_master dut (
        .clk_d  (clk_d),
        .rst_d  (rst_d),
        .bus    (bus),
        .busy   (busy),
        .clk_a  (clk_a),
        .we_a   (we_a),
        .addr_a (addr_a),
        .din_a  (din_a),
        .dout_a (dout_a)
    );

    int checks_done;
    int checks_failed;
    int cycle;
    int accept_cycle;
    int overlap_err;

    logic [7:0]      mem [0:15];
    logic            prev_clk_hi;
    logic [3:0]      dec_addr;
    logic [7:0]      dec_din;
    logic            ovr_en;
    logic [7:0][7:0] ovr_val;

    initial clk_d = 1'b0;
    always #5 clk_d = ~clk_d;

    always @(posedge clk_d) cycle <= cycle + 1;

    // SRAM model: its own comparator at mid-scale, writes on the rising edge of clk_a.
    always_comb begin
        dec_addr = '0;
        dec_din  = '0;
        for (int i = 0; i < 4; i++) dec_addr[i] = (addr_a[i] > 8'd128);
        for (int i = 0; i < 8; i++) dec_din[i]  = (din_a[i] > 8'd128);
    end

    always @(negedge clk_d) begin
        if ((clk_a > 8'd128) && !prev_clk_hi && (we_a > 8'd128)) mem[dec_addr] = dec_din;
        prev_clk_hi = (clk_a > 8'd128);
    end

    always_comb begin
        dout_a = '0;
        for (int i = 0; i < 8; i++) begin
            dout_a[i] = ovr_en ? ovr_val[i] : (mem[dec_addr][i] ? 8'd255 : 8'd0);
        end
    end

    always @(negedge clk_d) begin
        if (!rst_d && ((bus.req_ready && busy) || (bus.req_ready && bus.rsp_valid))) overlap_err++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_done++;
        if (got !== exp) begin
            checks_failed++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [7:0] wdata);
        int waited;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        waited = 0;
        while (!bus.req_ready && waited < 50) begin
            @(posedge clk_d); #1;
            waited++;
        end
        if (!bus.req_ready) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk_d); #1;
        accept_cycle  = cycle;
        bus.req_valid = 1'b0;
    endtask

    task automatic waitResponse(output logic got_we, output logic [7:0] got_data, output int lat);
        int waited;
        waited   = 0;
        got_we   = 1'bx;
        got_data = 'x;
        lat      = -1;
        while (!bus.rsp_valid && waited < 50) begin
            @(posedge clk_d); #1;
            waited++;
        end
        if (!bus.rsp_valid) begin
            checkOutput("rsp_timeout", 64'd0, 64'd1);
        end else begin
            got_we   = bus.rsp_we;
            got_data = bus.rsp_rdata;
            lat      = cycle - accept_cycle;
            while (bus.rsp_valid && !bus.rsp_ready) begin
                @(posedge clk_d); #1;
            end
            @(posedge clk_d); #1;
        end
    endtask

    task automatic doTransaction(input string tag, input logic we, input logic [3:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] exp_data);
        logic       got_we;
        logic [7:0] got_data;
        int         lat;
        applyStimulus(we, addr, wdata);
        waitResponse(got_we, got_data, lat);
        checkOutput({tag, "_we"}, 64'(got_we), 64'(we));
        checkOutput({tag, "_data"}, 64'(got_data), 64'(exp_data));
    endtask

    initial begin
        logic       got_we;
        logic [7:0] got_data;
        int         lat;
        int         seen;

        checks_done   = 0;
        checks_failed = 0;
        overlap_err   = 0;
        cycle         = 0;
        rst_d         = 1'b1;
        ovr_en        = 1'b0;
        ovr_val       = '0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(posedge clk_d);
        #1;
        checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd1);
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_clk_a", 64'(clk_a), 64'd0);
        checkOutput("rst_addr_a", 64'(addr_a), 64'd0);
        @(negedge clk_d);
        rst_d = 1'b0;
        @(posedge clk_d); #1;

        $display("[TB] write then read at address 3");
        applyStimulus(1'b1, 4'd3, 8'hA5);
        checkOutput("wr_we_a", 64'(we_a), 64'd255);
        checkOutput("wr_addr_a", 64'(addr_a), 64'h0000_FFFF);
        checkOutput("wr_din_a", 64'(din_a), 64'hFF00_FF00_00FF_00FF);
        waitResponse(got_we, got_data, lat);
        checkOutput("wr_rsp_we", 64'(got_we), 64'd1);
        checkOutput("wr_rsp_rdata", 64'(got_data), 64'd0);
        checkOutput("wr_latency", 64'(lat), 64'd8);
        checkOutput("idle_we_a", 64'(we_a), 64'd0);
        checkOutput("idle_addr_hold", 64'(addr_a), 64'h0000_FFFF);
        doTransaction("rd3", 1'b0, 4'd3, 8'h00, 8'hA5);

        $display("[TB] read timing, counted in clock edges after the accept edge");
        applyStimulus(1'b0, 4'd3, 8'h00);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("clk_a_k%0d", k), 64'(clk_a), (k == 1 || k == 2) ? 64'd255 : 64'd0);
            checkOutput($sformatf("rsp_valid_k%0d", k), 64'(bus.rsp_valid), (k == 8) ? 64'd1 : 64'd0);
            if (k == 8) checkOutput("timing_rdata", 64'(bus.rsp_rdata), 64'hA5);
            @(posedge clk_d); #1;
        end

        $display("[TB] slicer threshold");
        ovr_en     = 1'b1;
        ovr_val    = '0;
        ovr_val[0] = 8'd128;
        ovr_val[1] = 8'd129;
        doTransaction("slicer", 1'b0, 4'd0, 8'h00, 8'h02);
        ovr_en = 1'b0;

        $display("[TB] response backpressure");
        bus.rsp_ready = 1'b0;
        applyStimulus(1'b0, 4'd3, 8'h00);
        seen = 0;
        while (!bus.rsp_valid && seen < 50) begin
            @(posedge clk_d); #1;
            seen++;
        end
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp_valid_%0d", k), 64'(bus.rsp_valid), 64'd1);
            checkOutput($sformatf("bp_rdata_%0d", k), 64'(bus.rsp_rdata), 64'hA5);
            checkOutput($sformatf("bp_req_ready_%0d", k), 64'(bus.req_ready), 64'd0);
            @(posedge clk_d); #1;
        end
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 4'd5;
        bus.req_wdata = 8'h3C;
        @(posedge clk_d); #1;
        checkOutput("bp_pending_ready", 64'(bus.req_ready), 64'd0);
        bus.rsp_ready = 1'b1;
        @(posedge clk_d); #1;
        checkOutput("bp_hs_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("bp_hs_req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk_d); #1;
        accept_cycle  = cycle;
        bus.req_valid = 1'b0;
        checkOutput("bp_accept_busy", 64'(busy), 64'd1);
        checkOutput("bp_accept_ready", 64'(bus.req_ready), 64'd0);
        waitResponse(got_we, got_data, lat);
        checkOutput("bp_wr_we", 64'(got_we), 64'd1);
        checkOutput("bp_wr_latency", 64'(lat), 64'd8);
        doTransaction("bp_rd5", 1'b0, 4'd5, 8'h00, 8'h3C);

        $display("[TB] reset during the clock-high phase");
        applyStimulus(1'b1, 4'd9, 8'hFF);
        @(posedge clk_d); #1;
        @(posedge clk_d); #1;
        checkOutput("mid_clk_a_high", 64'(clk_a), 64'd255);
        rst_d = 1'b1;
        #1;
        checkOutput("mid_rst_clk_a", 64'(clk_a), 64'd0);
        checkOutput("mid_rst_we_a", 64'(we_a), 64'd0);
        checkOutput("mid_rst_addr_a", 64'(addr_a), 64'd0);
        checkOutput("mid_rst_din_a", 64'(din_a), 64'd0);
        checkOutput("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk_d);
        rst_d = 1'b0;
        @(posedge clk_d); #1;
        checkOutput("post_rst_ready", 64'(bus.req_ready), 64'd1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.rsp_valid) seen++;
            @(posedge clk_d); #1;
        end
        checkOutput("post_rst_no_rsp", 64'(seen), 64'd0);
        doTransaction("post_rst_wr7", 1'b1, 4'd7, 8'h5A, 8'h00);
        doTransaction("post_rst_rd7", 1'b0, 4'd7, 8'h00, 8'h5A);

        $display("[TB] back-to-back sweep of all addresses");
        for (int i = 0; i < 16; i++) begin
            doTransaction($sformatf("b2b_wr%0d", i), 1'b1, 4'(i), 8'(8'hFF - i), 8'h00);
        end
        for (int i = 0; i < 16; i++) begin
            doTransaction($sformatf("b2b_rd%0d", i), 1'b0, 4'(i), 8'h00, 8'(8'hFF - i));
        end
        checkOutput("no_overlap", 64'(overlap_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end

endmodule
